time_convert: RTL and testbench
===============================

# time_convert

Inverse of the meter's cost conversion: turns deposited coins into purchased parking seconds. Accepts one coin at a time over a valid/ready handshake. Converts cents to seconds at the rate selected by the hour switches, using a sequential shift-add multiplier. Accumulates the result into a saturating 12-bit seconds balance that counts down on a 1 Hz tick; `sec_count` feeds the display and the cost path.

## Interface

Parameters:
- `SEC_MAX`, 4095: saturation ceiling of the seconds balance; must fit in 12 bits.

Ports:
- `clk`  in  1  system clock; the block's only clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `sw`  in  8  `[7:5]` location (ignored by this block), `[4:0]` hour 0–23.
- `tick_1hz`  in  1  single-cycle pulse, once per second.
- `clear`  in  1  synchronous; zeroes the balance and aborts any conversion.
- `coin_valid`  in  1  coin present on `coin_cents`.
- `coin_cents`  in  7  coin value in cents, 0–127.
- `coin_ready`  out  1  block can accept a coin.
- `sec_count`  out  12  remaining purchased seconds.
- `expired`  out  1  high while `sec_count == 0`.
- `sat`  out  1  one-cycle pulse: the last add was clipped to `SEC_MAX`.
- `reject`  out  1  one-cycle pulse: the last coin was taken at an invalid hour.

## Operation

**Rate by hour**
- Hours 0–7 and 18–23 cost 1 c/min, so the multiplier is 60 s/cent.
- Hours 8–17 cost 2 c/min, so the multiplier is 30 s/cent.
- Hours 24–31 are invalid.
- The multiplier and the hour-valid flag are latched at coin acceptance. Hour changes during a conversion have no effect on it.

**State machine**
- IDLE
  - `coin_ready`=1.
  - If `coin_valid` && `coin_ready` at an edge: latch `coin_cents`, the multiplier and the valid flag; clear the product; move to CONV with bit index 0.
- CONV (7 cycles, bit index i = 0..6)
  - At each edge, if latched cents bit i is 1, add (multiplier << i) to the product.
  - After i = 6, move to ACCUM.
- ACCUM (1 cycle)
  - Addend = product if the hour was valid, else 0.
  - Pulse `reject` if the hour was invalid.
  - Update the balance (rule below) and return to IDLE.
- `coin_ready` is registered: low from the acceptance edge until the ACCUM edge, high again after the ACCUM edge.

**Arithmetic**
- Product register is 13 bits; the maximum is 127 × 60 = 7620.
- Balance update is computed in 14 bits:
  - base = `sec_count` − (`tick_1hz` && `sec_count` != 0)
  - next = min(base + addend, `SEC_MAX`)
- `sat` pulses when base + addend > `SEC_MAX`.
- Outside ACCUM: if `tick_1hz` && `sec_count` != 0, decrement by 1; the balance never wraps below 0.
- `coin_cents` = 0 is accepted, adds 0, and produces no `reject` and no `sat`.

**Precedence**
- `clear` > ACCUM/tick > everything else.
- `clear` forces `sec_count`=0, state IDLE, product 0, `coin_ready`=1 on the next cycle. A coin presented in the same cycle as `clear` is not accepted.

**Reset** (async, `rst_n`=0)
- State IDLE.
- `sec_count`=0, `coin_ready`=0, `sat`=0, `reject`=0, product 0.
- `expired`=1 (registered, mirrors `sec_count == 0`).
- `coin_ready` rises at the first edge after `rst_n` deasserts.
- Reset in mid-conversion discards the coin.

## Timing

- Acceptance at edge E0. CONV occupies edges E1–E7. `sec_count`, `sat` and `reject` update at edge E8. `coin_ready` goes high after E8.
- Earliest next acceptance is edge E9, so throughput is 1 coin per 9 cycles.
- `expired` is registered, updating at the same edge as `sec_count`.
- `sat` and `reject` last exactly one cycle.
- `tick_1hz` is honoured in every state, including CONV, so countdown never stalls.
- `coin_valid` may stay high while `coin_ready` is low; the coin is held by the sender until the handshake completes.

## Test plan

- **Afternoon rate:** reset, `sw`=8'b000_01001 (hour 9), coin 25 → `coin_ready` low for edges E1–E8, `sec_count`=750 at E8, `expired` drops, no `sat`.
- **Saturation:** hour 2, coin 100 → 6000 clipped, `sec_count`=4095, `sat` pulses for 1 cycle. A second coin 5 → stays 4095, `sat` pulses again.
- **Invalid hour:** hour 25, coin 10 with `sec_count`=300 → `sec_count` stays 300 (no tick), `reject` pulses at E8, `coin_ready` returns high.
- **Countdown floor:** `sec_count`=3, four `tick_1hz` pulses → 2, 1, 0, 0; `expired`=1 after the third tick; no wrap to 4095.
- **Tick at ACCUM:** hour 20, `sec_count`=100, coin 5 with `tick_1hz` on the ACCUM edge → `sec_count`=399.
- **Abort:** assert `clear` at E3 of a coin 50 conversion → `sec_count`=0, `coin_ready`=1 next cycle, no later add. Repeat with `rst_n` low at E5 → all outputs at reset values, `coin_ready` rises one edge after release.

Source files
------------

// File: rtl/time_convert.sv
// Coin-to-seconds converter for the parking meter: a shift-add multiply at an hour-dependent rate
// feeds a saturating 12-bit seconds balance that counts down on the 1 Hz tick.
module time_convert #(
  parameter int SEC_MAX = 4095
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  sw,
  input  logic        tick_1hz,
  input  logic        clear,
  input  logic        coin_valid,
  input  logic [6:0]  coin_cents,
  output logic        coin_ready,
  output logic [11:0] sec_count,
  output logic        expired,
  output logic        sat,
  output logic        reject
);

  typedef enum logic [1:0] {IDLE, CONV, ACCUM} state_t;

  localparam logic [13:0] SEC_LIM = 14'(SEC_MAX);

  state_t      state, state_next;
  logic [6:0]  cents_q, cents_next;
  logic [5:0]  mult_q, mult_next;
  logic        hour_ok_q, hour_ok_next;
  logic [2:0]  bit_idx, bit_next;
  logic [12:0] product, product_next;
  logic [11:0] sec_next;
  logic        ready_next, expired_next, sat_next, reject_next;

  logic [4:0]  hour;
  logic        hour_ok;
  logic [5:0]  rate_mult;
  logic        dec;
  logic [13:0] base, addend, sum;
  logic        unused_location;

  // Location bits belong to other blocks of the meter.
  assign unused_location = ^sw[7:5];

  assign hour      = sw[4:0];
  assign hour_ok   = (hour < 5'd24);
  assign rate_mult = (hour >= 5'd8 && hour <= 5'd17) ? 6'd30 : 6'd60;

  always_comb begin
    state_next   = state;
    cents_next   = cents_q;
    mult_next    = mult_q;
    hour_ok_next = hour_ok_q;
    bit_next     = bit_idx;
    product_next = product;
    ready_next   = coin_ready;
    sat_next     = 1'b0;
    reject_next  = 1'b0;
    addend       = 14'd0;

    dec      = tick_1hz && (sec_count != 12'd0);
    base     = {2'b00, sec_count} - {13'd0, dec};
    sum      = base;
    sec_next = base[11:0];

    case (state)
      IDLE: begin
        ready_next = 1'b1;
        if (coin_valid && coin_ready) begin
          cents_next   = coin_cents;
          mult_next    = rate_mult;
          hour_ok_next = hour_ok;
          product_next = 13'd0;
          bit_next     = 3'd0;
          state_next   = CONV;
          ready_next   = 1'b0;
        end
      end
      CONV: begin
        if (cents_q[bit_idx])
          product_next = product + (13'(mult_q) << bit_idx);
        bit_next = bit_idx + 3'd1;
        if (bit_idx == 3'd6)
          state_next = ACCUM;
      end
      ACCUM: begin
        addend      = hour_ok_q ? {1'b0, product} : 14'd0;
        reject_next = !hour_ok_q;
        sum         = base + addend;
        if (sum > SEC_LIM) begin
          sec_next = SEC_LIM[11:0];
          sat_next = 1'b1;
        end else begin
          sec_next = sum[11:0];
        end
        state_next = IDLE;
        ready_next = 1'b1;
      end
      default: begin
        state_next = IDLE;
        ready_next = 1'b1;
      end
    endcase

    // Clear wins over everything, including a coin offered in the same cycle.
    if (clear) begin
      state_next   = IDLE;
      product_next = 13'd0;
      bit_next     = 3'd0;
      sec_next     = 12'd0;
      ready_next   = 1'b1;
      sat_next     = 1'b0;
      reject_next  = 1'b0;
    end

    expired_next = (sec_next == 12'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cents_q    <= 7'd0;
      mult_q     <= 6'd0;
      hour_ok_q  <= 1'b0;
      bit_idx    <= 3'd0;
      product    <= 13'd0;
      sec_count  <= 12'd0;
      coin_ready <= 1'b0;
      expired    <= 1'b1;
      sat        <= 1'b0;
      reject     <= 1'b0;
    end else begin
      state      <= state_next;
      cents_q    <= cents_next;
      mult_q     <= mult_next;
      hour_ok_q  <= hour_ok_next;
      bit_idx    <= bit_next;
      product    <= product_next;
      sec_count  <= sec_next;
      coin_ready <= ready_next;
      expired    <= expired_next;
      sat        <= sat_next;
      reject     <= reject_next;
    end
  end

endmodule

// File: tb/tb_time_convert.sv
// Directed bench for time_convert: hand-computed balances for rate, saturation,
// invalid hour, countdown floor, tick at accumulate, clear and reset aborts.
module tb_time_convert;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  sw;
  logic        tick_1hz;
  logic        clear;
  logic        coin_valid;
  logic [6:0]  coin_cents;
  logic        coin_ready;
  logic [11:0] sec_count;
  logic        expired;
  logic        sat;
  logic        reject;

  int checks = 0;
  int passes = 0;

  time_convert #(.SEC_MAX(4095)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sw         (sw),
    .tick_1hz   (tick_1hz),
    .clear      (clear),
    .coin_valid (coin_valid),
    .coin_cents (coin_cents),
    .coin_ready (coin_ready),
    .sec_count  (sec_count),
    .expired    (expired),
    .sat        (sat),
    .reject     (reject)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checks++;
    assert (observed === expected) passes++;
    else $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
  endtask

  task automatic stepClock();
    @(posedge clk);
    #1;
  endtask

  task automatic waitReady();
    for (int i = 0; i < 20; i++) begin
      if (coin_ready === 1'b1) break;
      stepClock();
    end
    checkOutput("ready_wait", 16'(coin_ready), 16'd1);
  endtask

  // Handshake through edge E0; the hour switches are then moved to an invalid hour
  // so any failure to latch the rate shows up in the result.
  task automatic startCoin(input logic [4:0] hr, input logic [6:0] cents);
    waitReady();
    sw         = {3'b101, hr};
    coin_cents = cents;
    coin_valid = 1'b1;
    stepClock();
    coin_valid = 1'b0;
    sw         = {3'b000, 5'd31};
    checkOutput("ready_low_e0", 16'(coin_ready), 16'd0);
  endtask

  // Runs a coin through E7; the caller steps the ACCUM edge E8 itself.
  task automatic applyStimulus(input logic [4:0] hr, input logic [6:0] cents);
    startCoin(hr, cents);
    repeat (7) stepClock();
    checkOutput("ready_low_e7", 16'(coin_ready), 16'd0);
  endtask

  task automatic doClear();
    clear = 1'b1;
    stepClock();
    clear = 1'b0;
    checkOutput("clear_sec", 16'(sec_count), 16'd0);
  endtask

  task automatic doTicks(input int n);
    for (int i = 0; i < n; i++) begin
      tick_1hz = 1'b1;
      stepClock();
    end
    tick_1hz = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; sw = 8'd0; tick_1hz = 1'b0; clear = 1'b0;
    coin_valid = 1'b0; coin_cents = 7'd0;

    // Reset values
    stepClock();
    checkOutput("rst_sec", 16'(sec_count), 16'd0);
    checkOutput("rst_ready", 16'(coin_ready), 16'd0);
    checkOutput("rst_expired", 16'(expired), 16'd1);
    checkOutput("rst_sat", 16'(sat), 16'd0);
    checkOutput("rst_reject", 16'(reject), 16'd0);
    rst_n = 1'b1;
    stepClock();
    checkOutput("ready_after_rst", 16'(coin_ready), 16'd1);

    // Afternoon rate: hour 9, 25 cents * 30 = 750
    startCoin(5'd9, 7'd25);
    for (int i = 1; i <= 7; i++) begin
      stepClock();
      checkOutput("ready_low_conv", 16'(coin_ready), 16'd0);
      checkOutput("sec_during_conv", 16'(sec_count), 16'd0);
    end
    stepClock();
    checkOutput("aft_sec", 16'(sec_count), 16'd750);
    checkOutput("aft_expired", 16'(expired), 16'd0);
    checkOutput("aft_sat", 16'(sat), 16'd0);
    checkOutput("aft_ready", 16'(coin_ready), 16'd1);

    // Saturation: hour 2, 100 cents * 60 = 6000 -> 4095
    doClear();
    applyStimulus(5'd2, 7'd100);
    stepClock();
    checkOutput("sat_sec", 16'(sec_count), 16'd4095);
    checkOutput("sat_pulse", 16'(sat), 16'd1);
    stepClock();
    checkOutput("sat_one_cycle", 16'(sat), 16'd0);
    checkOutput("sat_hold", 16'(sec_count), 16'd4095);
    applyStimulus(5'd2, 7'd5);
    stepClock();
    checkOutput("sat2_sec", 16'(sec_count), 16'd4095);
    checkOutput("sat2_pulse", 16'(sat), 16'd1);
    stepClock();
    checkOutput("sat2_one_cycle", 16'(sat), 16'd0);

    // Invalid hour: balance 300, hour 25 coin 10 rejected
    doClear();
    applyStimulus(5'd2, 7'd5);
    stepClock();
    checkOutput("inv_pre_sec", 16'(sec_count), 16'd300);
    applyStimulus(5'd25, 7'd10);
    stepClock();
    checkOutput("inv_sec", 16'(sec_count), 16'd300);
    checkOutput("inv_reject", 16'(reject), 16'd1);
    checkOutput("inv_ready", 16'(coin_ready), 16'd1);
    checkOutput("inv_sat", 16'(sat), 16'd0);
    stepClock();
    checkOutput("inv_reject_one", 16'(reject), 16'd0);

    // Zero-cent coin is accepted and adds nothing
    applyStimulus(5'd9, 7'd0);
    stepClock();
    checkOutput("zero_sec", 16'(sec_count), 16'd300);
    checkOutput("zero_sat", 16'(sat), 16'd0);
    checkOutput("zero_reject", 16'(reject), 16'd0);

    // Countdown floor: 30 - 27 ticks = 3, then 2, 1, 0, 0
    doClear();
    applyStimulus(5'd9, 7'd1);
    stepClock();
    checkOutput("cd_load", 16'(sec_count), 16'd30);
    doTicks(27);
    checkOutput("cd_three", 16'(sec_count), 16'd3);
    doTicks(1);
    checkOutput("cd_two", 16'(sec_count), 16'd2);
    doTicks(1);
    checkOutput("cd_one", 16'(sec_count), 16'd1);
    checkOutput("cd_not_expired", 16'(expired), 16'd0);
    doTicks(1);
    checkOutput("cd_zero", 16'(sec_count), 16'd0);
    checkOutput("cd_expired", 16'(expired), 16'd1);
    doTicks(1);
    checkOutput("cd_floor", 16'(sec_count), 16'd0);

    // Tick at ACCUM: 120 - 20 = 100, then 100 - 1 + 5*60 = 399
    applyStimulus(5'd9, 7'd4);
    stepClock();
    checkOutput("ta_load", 16'(sec_count), 16'd120);
    doTicks(20);
    checkOutput("ta_base", 16'(sec_count), 16'd100);
    applyStimulus(5'd20, 7'd5);
    tick_1hz = 1'b1;
    stepClock();
    tick_1hz = 1'b0;
    checkOutput("ta_sec", 16'(sec_count), 16'd399);

    // Tick during conversion still counts down: 399 - 1 + 30 = 428
    startCoin(5'd9, 7'd1);
    stepClock();
    stepClock();
    doTicks(1);
    checkOutput("tconv_sec", 16'(sec_count), 16'd398);
    repeat (4) stepClock();
    stepClock();
    checkOutput("tconv_final", 16'(sec_count), 16'd428);

    // Abort by clear at E3 of a 50-cent conversion
    startCoin(5'd9, 7'd50);
    stepClock();
    stepClock();
    clear = 1'b1;
    stepClock();
    clear = 1'b0;
    checkOutput("abort_sec", 16'(sec_count), 16'd0);
    checkOutput("abort_ready", 16'(coin_ready), 16'd1);
    checkOutput("abort_expired", 16'(expired), 16'd1);
    repeat (10) stepClock();
    checkOutput("abort_no_add", 16'(sec_count), 16'd0);

    // Abort by reset at E5
    applyStimulus(5'd9, 7'd1);
    stepClock();
    checkOutput("rabort_load", 16'(sec_count), 16'd30);
    startCoin(5'd9, 7'd50);
    repeat (4) stepClock();
    rst_n = 1'b0;
    #1;
    checkOutput("rabort_sec", 16'(sec_count), 16'd0);
    checkOutput("rabort_ready", 16'(coin_ready), 16'd0);
    checkOutput("rabort_expired", 16'(expired), 16'd1);
    checkOutput("rabort_sat", 16'(sat), 16'd0);
    checkOutput("rabort_reject", 16'(reject), 16'd0);
    stepClock();
    stepClock();
    rst_n = 1'b1;
    checkOutput("rabort_ready_held", 16'(coin_ready), 16'd0);
    stepClock();
    checkOutput("rabort_ready_rise", 16'(coin_ready), 16'd1);
    repeat (10) stepClock();
    checkOutput("rabort_no_add", 16'(sec_count), 16'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
